// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared constants and read-FSM state type for the OFDM
// Hermitian frame scheduler.
`timescale 1ns/1ps
package ofdm_pkg;

    localparam int N_FFT   = 64;
    localparam int N_DATA  = 31;
    localparam int DC_IDX  = 0;
    localparam int NYQ_IDX = 32;

    // Read-side FSM states. CP is only reachable when cyclic-prefix
    // insertion is compiled in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        BODY = 2'd2
    } rd_state_t;

endpackage

// File: rtl/hermitian_idx_map.sv
// hermitian_idx_map: maps a 64-point IFFT bin index onto the symbol
// buffer. Bins 0 (DC) and 32 (Nyquist) are zero, bins 1..31 read the data
// directly and bins 33..63 read the mirrored symbol with conjugation.
`timescale 1ns/1ps
module hermitian_idx_map
    import ofdm_pkg::*;
(
    input  logic [5:0] idx,
    output logic [4:0] rd_addr,
    output logic       rd_zero,
    output logic       rd_conj
);

    // Pure decode of the bin index; zero bins always report address 0.
    always_comb begin
        rd_addr = 5'd0;
        rd_zero = 1'b0;
        rd_conj = 1'b0;
        if (idx == 6'(DC_IDX) || idx == 6'(NYQ_IDX)) begin
            rd_zero = 1'b1;
        end else if (idx < 6'(NYQ_IDX)) begin
            rd_addr = 5'(idx - 6'd1);
        end else begin
            rd_addr = 5'(6'(N_FFT - 1) - idx);
            rd_conj = 1'b1;
        end
    end

endmodule

// File: rtl/ofdm_frame_sched.sv
// ofdm_frame_sched: ping-pong symbol buffer controller that sequences the
// 64-sample Hermitian frame ahead of the IFFT.
//
// Handshakes: a transfer happens on a rising clk_div edge where valid and
// ready are both high; valid never waits on ready, and while valid is high
// and ready low every output of that channel is held unchanged.
//
// Optional feature: define OFDM_CP_INSERT_EN to emit CP_LEN cyclic-prefix
// samples (bins 64-CP_LEN..63) in front of each 64-sample body.
`timescale 1ns/1ps
module ofdm_frame_sched
    import ofdm_pkg::*;
#(
    parameter int FCNT_W = 16
`ifdef OFDM_CP_INSERT_EN
    , parameter int CP_LEN = 16
`endif
) (
    input  logic              clk_div,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [4:0]        wr_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rd_bank,
    output logic [4:0]        rd_addr,
    output logic              rd_zero,
    output logic              rd_conj,
    output logic [5:0]        sample_idx,
    output logic              sof,
    output logic              eof,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [5:0] LAST_IDX = 6'(N_FFT - 1);
`ifdef OFDM_CP_INSERT_EN
    localparam rd_state_t  FIRST_ST  = CP;
    localparam logic [5:0] FIRST_IDX = 6'(N_FFT - CP_LEN);
`else
    localparam rd_state_t  FIRST_ST  = BODY;
    localparam logic [5:0] FIRST_IDX = 6'd0;
`endif

    logic [1:0] full;
    logic       wr_done;
    logic       rd_done;
    logic       other_full_nxt;
    rd_state_t  state;
    rd_state_t  state_nxt;
    logic [5:0] idx_nxt;
    logic       ov_nxt;
    logic       sof_nxt;
    logic       eof_nxt;
    logic [4:0] map_addr;
    logic       map_zero;
    logic       map_conj;

    // A bank being full blocks writes into it; nothing is accepted in reset.
    assign in_ready = reset_n & ~full[wr_bank];
    assign wr_en    = in_valid & in_ready;
    assign wr_done  = wr_en && (wr_addr == 5'(N_DATA - 1));

    // The bank not being drained is full next cycle if it already is, or
    // if its last symbol lands this cycle (enables gap-free frame chaining).
    assign other_full_nxt = full[~rd_bank] | (wr_done & (wr_bank != rd_bank));

    hermitian_idx_map u_map (
        .idx     (idx_nxt),
        .rd_addr (map_addr),
        .rd_zero (map_zero),
        .rd_conj (map_conj)
    );

    // Bank bookkeeping: write pointer, full flags, read bank and frame count.
    always_ff @(posedge clk_div) begin
        if (!reset_n) begin
            wr_bank   <= 1'b0;
            wr_addr   <= 5'd0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            frame_cnt <= '0;
        end else begin
            if (wr_en) begin
                if (wr_done) begin
                    wr_addr <= 5'd0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + 5'd1;
                end
            end
            if (wr_done) full[wr_bank] <= 1'b1;
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                frame_cnt     <= frame_cnt + {{(FCNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Read FSM next state: entering a frame loads its first index with
    // out_valid still low, so the sample appears one edge later.
    always_comb begin
        state_nxt = state;
        idx_nxt   = sample_idx;
        ov_nxt    = out_valid;
        sof_nxt   = sof;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = FIRST_ST;
                    idx_nxt   = FIRST_IDX;
                    sof_nxt   = 1'b1;
                end
            end
`ifdef OFDM_CP_INSERT_EN
            CP: begin
                if (!out_valid) begin
                    ov_nxt = 1'b1;
                end else if (out_ready) begin
                    sof_nxt = 1'b0;
                    if (sample_idx == LAST_IDX) begin
                        state_nxt = BODY;
                        idx_nxt   = 6'd0;
                    end else begin
                        idx_nxt = sample_idx + 6'd1;
                    end
                end
            end
`endif
            BODY: begin
                if (!out_valid) begin
                    ov_nxt = 1'b1;
                end else if (out_ready) begin
                    sof_nxt = 1'b0;
                    if (sample_idx == LAST_IDX) begin
                        rd_done = 1'b1;
                        if (other_full_nxt) begin
                            state_nxt = FIRST_ST;
                            idx_nxt   = FIRST_IDX;
                            sof_nxt   = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            idx_nxt   = 6'd0;
                            ov_nxt    = 1'b0;
                        end
                    end else begin
                        idx_nxt = sample_idx + 6'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 6'd0;
                ov_nxt    = 1'b0;
                sof_nxt   = 1'b0;
            end
        endcase
        eof_nxt = (state_nxt == BODY) && (idx_nxt == LAST_IDX);
    end

    // Registered sample outputs; a stall leaves idx_nxt unchanged so every
    // output holds.
    always_ff @(posedge clk_div) begin
        if (!reset_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            sample_idx <= 6'd0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            rd_addr    <= 5'd0;
            rd_zero    <= 1'b0;
            rd_conj    <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_valid  <= ov_nxt;
            sample_idx <= idx_nxt;
            sof        <= sof_nxt;
            eof        <= eof_nxt;
            rd_addr    <= (state_nxt == IDLE) ? 5'd0 : map_addr;
            rd_zero    <= (state_nxt != IDLE) & map_zero;
            rd_conj    <= (state_nxt != IDLE) & map_conj;
        end
    end

endmodule

// File: tb/tb_ofdm_frame_sched.sv
// tb_ofdm_frame_sched: randomized bench with a frame-level reference model.
// Each completed 31-symbol frame queues its expected sample stream, built
// by placing data symbol k at bin k+1 and its conjugate at bin 63-k.
`timescale 1ns/1ps
module tb_ofdm_frame_sched;
    import ofdm_pkg::*;

`ifdef OFDM_CP_INSERT_EN
    localparam int CP_LEN = 16;
`else
    localparam int CP_LEN = 0;
`endif

    logic        clk_div = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic        wr_bank;
    logic [4:0]  wr_addr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        rd_bank;
    logic [4:0]  rd_addr;
    logic        rd_zero;
    logic        rd_conj;
    logic [5:0]  sample_idx;
    logic        sof;
    logic        eof;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    int          w_cnt = 0;
    int          f_rd = 0;
    int          wait_cnt = 0;
    bit          prev_eof_hs = 1'b0;

    // clock / reset
    always #5 clk_div = ~clk_div;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    ofdm_frame_sched dut (
        .clk_div    (clk_div),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .rd_zero    (rd_zero),
        .rd_conj    (rd_conj),
        .sample_idx (sample_idx),
        .sof        (sof),
        .eof        (eof),
        .frame_cnt  (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected sample word: {bank, addr, zero, conj, idx, sof, eof}.
    function automatic logic [15:0] pack_s(input bit bank, input int idx, input bit s, input bit e);
        logic [4:0] a;
        bit z;
        bit c;
        z = 1'b1;
        a = 5'd0;
        c = 1'b0;
        for (int k = 1; k <= N_DATA; k++) begin
            if (idx == k) begin
                z = 1'b0;
                a = 5'(k - 1);
                c = 1'b0;
            end
            if (idx == 64 - k) begin
                z = 1'b0;
                a = 5'(k - 1);
                c = 1'b1;
            end
        end
        return {bank, a, z, c, 6'(idx), s, e};
    endfunction

    task automatic push_frame(input int f);
        bit bank;
        bank = f[0];
        for (int k = 64 - CP_LEN; k < 64; k++)
            exp_q.push_back(pack_s(bank, k, k == 64 - CP_LEN, 1'b0));
        for (int k = 0; k < 64; k++)
            exp_q.push_back(pack_s(bank, k, (CP_LEN == 0) && (k == 0), k == 63));
    endtask

    // driver: one clock of stimulus plus scoreboard update
    task automatic step(input bit iv, input bit ordy, input bit sync_eof);
        logic [15:0] got;
        bit hs_wr;
        bit hs_rd;
        int pend;
        @(negedge clk_div);
        pend = (w_cnt / N_DATA) - f_rd;
        check("frame_cnt", 32'(frame_cnt), 32'(16'(f_rd)));
        check("in_ready", 32'(in_ready), (pend < 2) ? 32'd1 : 32'd0);
        check("wr_bank", 32'(wr_bank), 32'((w_cnt / N_DATA) % 2));
        check("wr_addr", 32'(wr_addr), 32'(w_cnt % N_DATA));
        if (prev_eof_hs && pend > 0) check("no_bubble", 32'(out_valid), 32'd1);
        got = {rd_bank, rd_addr, rd_zero, rd_conj, sample_idx, sof, eof};
        if (out_valid) begin
            if (wait_cnt != 0) check("latency", 32'(wait_cnt), 32'd2);
            wait_cnt = 0;
            if (exp_q.size() == 0) check("spurious_out", 32'(got), 32'hffff_ffff);
            else check("sample", 32'(got), 32'(exp_q[0]));
        end else if (exp_q.size() > 0) begin
            wait_cnt++;
            if (wait_cnt > 2) check("start_delay", 32'(wait_cnt), 32'd2);
        end
        in_valid  = sync_eof ? (out_valid && eof) : iv;
        out_ready = ordy;
        #1;
        hs_wr = in_valid && in_ready;
        hs_rd = out_valid && out_ready;
        check("wr_en", 32'(wr_en), 32'(hs_wr));
        prev_eof_hs = 1'b0;
        if (hs_rd && exp_q.size() > 0) begin
            prev_eof_hs = exp_q[0][0];
            if (exp_q[0][0]) f_rd++;
            void'(exp_q.pop_front());
        end
        if (hs_wr) begin
            w_cnt++;
            if (w_cnt % N_DATA == 0) push_frame((w_cnt / N_DATA) - 1);
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk_div);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        w_cnt = 0;
        f_rd = 0;
        wait_cnt = 0;
        prev_eof_hs = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_div);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_wr_en", 32'(wr_en), 32'd0);
            check("rst_ctrl", 32'({wr_bank, wr_addr, rd_bank, out_valid, sof, eof,
                                   rd_zero, rd_conj, sample_idx, rd_addr}), 32'd0);
            check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        end
        reset_n = 1'b1;
    endtask

    task automatic feed(input int nsym, input int pv, input int pr);
        int target;
        target = w_cnt + nsym;
        for (int i = 0; i < 5000 && w_cnt < target; i++)
            step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr, 1'b0);
        if (w_cnt < target) check("feed_timeout", 32'(w_cnt), 32'(target));
    endtask

    task automatic drain(input int pr, input int lim);
        for (int i = 0; i < lim && (exp_q.size() != 0 || out_valid); i++)
            step(1'b0, $urandom_range(0, 99) < pr, 1'b0);
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        apply_reset(3);

        // single frame, no backpressure
        feed(N_DATA, 100, 100);
        drain(100, 300);
        check("single_frame_cnt", 32'(frame_cnt), 32'd1);

        // two frames with random valid and 50% out_ready
        feed(2 * N_DATA, 70, 50);
        drain(50, 3000);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd3);

        // three frames back to back
        feed(3 * N_DATA, 100, 100);
        drain(100, 600);
        check("b2b_frame_cnt", 32'(frame_cnt), 32'd6);

        // last write of bank 1 lands with the eof handshake of bank 0
        apply_reset(1);
        feed(N_DATA, 100, 0);
        feed(N_DATA - 1, 100, 0);
        for (int i = 0; i < 400 && w_cnt < 2 * N_DATA; i++) step(1'b0, 1'b1, 1'b1);
        check("simul_writes", 32'(w_cnt), 32'(2 * N_DATA));
        step(1'b0, 1'b1, 1'b0);
        check("simul_next", 32'({out_valid, sof, rd_bank}), 32'b111);
        drain(100, 300);
        check("simul_frame_cnt", 32'(frame_cnt), 32'd2);

        // reset in the middle of a frame, then a clean frame
        feed(N_DATA, 100, 100);
        for (int i = 0; i < 300 && !(out_valid && sample_idx == 6'd20); i++)
            step(1'b0, 1'b1, 1'b0);
        check("mid_idx_reached", 32'(sample_idx), 32'd20);
        apply_reset(2);
        feed(N_DATA, 100, 100);
        drain(100, 300);
        check("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);

        // random soak
        feed(4 * N_DATA, 50, 60);
        drain(60, 4000);
        check("soak_frame_cnt", 32'(frame_cnt), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
